// File: rtl/truth_table_checker.sv
// Self-checking harness for a 2-input AND gate. Vectors are accepted with a
// vld/rdy handshake, the gate output c is sampled a fixed number of edges
// later, and mismatches, error count and input coverage are accumulated
// until all four input combinations have been checked.
module truth_table_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld,
  output logic             rdy,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             done,
  output logic             pass
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT,
    CHECK,
    DONE
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic       cap_a;
  logic       cap_b;
  logic       exp_c;
  logic [3:0] cov_upd;

  // Coverage as it will look after the vector currently held is checked.
  always_comb begin
    cov_upd                = cov;
    cov_upd[{cap_a, cap_b}] = 1'b1;
    exp_c                  = cap_a & cap_b;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start overrides everything except reset, including
  // a vld in the same cycle and any vector still settling.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUN;
    end else begin
      case (state)
        IDLE:  state_next = IDLE;
        RUN:   if (vld) state_next = (SETTLE_CYCLES == 1) ? CHECK : WAIT;
        WAIT:  if (settle_cnt <= 4'd1) state_next = CHECK;
        CHECK: state_next = (cov_upd == 4'hF) ? DONE : RUN;
        DONE:  state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: vector capture, settle counter, compare, error and coverage.
  // rdy is registered from the next state so it tracks RUN exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy        <= 1'b0;
      mismatch   <= 1'b0;
      err_cnt    <= '0;
      cov        <= '0;
      settle_cnt <= '0;
      cap_a      <= 1'b0;
      cap_b      <= 1'b0;
    end else begin
      rdy      <= (state_next == RUN);
      mismatch <= 1'b0;
      if (start) begin
        cov        <= '0;
        err_cnt    <= '0;
        settle_cnt <= '0;
      end else begin
        case (state)
          RUN: begin
            if (vld) begin
              cap_a      <= a;
              cap_b      <= b;
              settle_cnt <= SETTLE_LOAD;
            end
          end
          WAIT: begin
            settle_cnt <= settle_cnt - 4'd1;
          end
          CHECK: begin
            cov <= cov_upd;
            if (c != exp_c) begin
              mismatch <= 1'b1;
              if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Completion flags decoded from state.
  always_comb begin
    done = (state == DONE);
    pass = (state == DONE) && (err_cnt == '0);
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized, self-checking bench for truth_table_checker. A transaction-level
// model tracks error count, coverage and completion per checked vector.
module tb_truth_table_checker;

  localparam int unsigned S       = 2;
  localparam int unsigned EW      = 2;
  localparam int          ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          vld = 1'b0;
  logic          rdy;
  logic          a = 1'b0;
  logic          b = 1'b0;
  logic          c = 1'b0;
  logic          mismatch;
  logic [EW-1:0] err_cnt;
  logic [3:0]    cov;
  logic          done;
  logic          pass;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int       m_errs = 0;
  bit [3:0] m_cov  = '0;
  bit       m_done = 1'b0;

  truth_table_checker #(
    .SETTLE_CYCLES(S),
    .ERR_W(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .vld(vld),
    .rdy(rdy),
    .a(a),
    .b(b),
    .c(c),
    .mismatch(mismatch),
    .err_cnt(err_cnt),
    .cov(cov),
    .done(done),
    .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_errs = 0;
    m_cov  = '0;
    m_done = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check_eq("start_rdy", rdy, 1);
    check_eq("start_err", err_cnt, 0);
    check_eq("start_cov", cov, 0);
    check_eq("start_done", done, 0);
    check_eq("start_mm", mismatch, 0);
  endtask

  // Offer one vector; c holds the complement of sample_c on every edge except
  // the one SETTLE edges after acceptance, so a mistimed sample is detected.
  task automatic do_vector(input bit ia, input bit ib, input bit sample_c);
    int  n;
    bit  bad;
    n = 0;
    while (!rdy && n < 20) begin
      tick();
      n++;
    end
    check_eq("rdy_wait", rdy, 1);
    a = ia; b = ib; vld = 1'b1; c = ~sample_c;
    tick();
    vld = 1'b0;
    a = 1'($urandom); b = 1'($urandom);
    for (int k = 1; k <= int'(S); k++) begin
      c = (k == int'(S)) ? sample_c : ~sample_c;
      check_eq("settle_rdy", rdy, 0);
      check_eq("settle_mm", mismatch, 0);
      tick();
    end
    c = ~sample_c;
    bad = (sample_c != (ia & ib));
    if (bad && m_errs < ERR_MAX) m_errs++;
    m_cov[{ia, ib}] = 1'b1;
    m_done = (m_cov == 4'hF);
    check_eq("vec_mm", mismatch, bad);
    check_eq("vec_err", err_cnt, m_errs);
    check_eq("vec_cov", cov, m_cov);
    check_eq("vec_done", done, m_done);
    check_eq("vec_pass", pass, m_done && (m_errs == 0));
    check_eq("vec_rdy", rdy, !m_done);
  endtask

  initial begin
    bit ra, rb, rc;
    int nv;

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_rdy", rdy, 0);
    check_eq("rst_mm", mismatch, 0);
    check_eq("rst_err", err_cnt, 0);
    check_eq("rst_cov", cov, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);

    // vld ignored in IDLE
    a = 1; b = 1; c = 0; vld = 1'b1;
    repeat (3) begin
      tick();
      check_eq("idle_rdy", rdy, 0);
      check_eq("idle_cov", cov, 0);
    end
    vld = 1'b0;

    // Correct gate, full sweep
    start_run();
    do_vector(0, 0, 0);
    do_vector(0, 1, 0);
    do_vector(1, 0, 0);
    do_vector(1, 1, 1);
    check_eq("sweep_pass", pass, 1);

    // vld ignored in DONE
    a = 0; b = 0; c = 1; vld = 1'b1;
    repeat (3) begin
      tick();
      check_eq("done_hold", done, 1);
      check_eq("done_err", err_cnt, 0);
    end
    vld = 1'b0;

    // c stuck at 1
    start_run();
    do_vector(0, 0, 1);
    do_vector(0, 1, 1);
    do_vector(1, 0, 1);
    do_vector(1, 1, 1);
    check_eq("stuck1_err", err_cnt, 3);
    check_eq("stuck1_pass", pass, 0);

    // Repeated vectors
    start_run();
    do_vector(1, 1, 1);
    do_vector(1, 1, 1);
    check_eq("rep_cov", cov, 4'b1000);
    do_vector(0, 0, 0);
    do_vector(0, 1, 0);
    check_eq("rep_notdone", done, 0);
    do_vector(1, 0, 0);
    check_eq("rep_done", done, 1);

    // Saturation with c stuck at 0
    start_run();
    repeat (6) do_vector(1, 1, 0);
    do_vector(0, 0, 0);
    do_vector(0, 1, 0);
    do_vector(1, 0, 0);
    check_eq("sat_err", err_cnt, 3);
    check_eq("sat_pass", pass, 0);

    // start while a vector is settling
    start_run();
    do_vector(1, 1, 0);
    a = 0; b = 0; c = 1; vld = 1'b1;
    tick();
    vld = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    check_eq("abort_err", err_cnt, 0);
    check_eq("abort_cov", cov, 0);
    check_eq("abort_rdy", rdy, 1);
    repeat (S + 1) begin
      tick();
      check_eq("abort_mm", mismatch, 0);
      check_eq("abort_err2", err_cnt, 0);
    end

    // start and vld together: start wins, vector dropped
    a = 1; b = 1; c = 0; vld = 1'b1; start = 1'b1;
    tick();
    vld = 1'b0; start = 1'b0;
    model_clear();
    check_eq("coll_rdy", rdy, 1);
    repeat (S + 1) begin
      tick();
      check_eq("coll_mm", mismatch, 0);
      check_eq("coll_cov", cov, 0);
    end

    // Reset while a mismatching vector is settling
    a = 1; b = 0; c = 1; vld = 1'b1;
    tick();
    vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < int'(S) + 2; k++) begin
      vld = 1'b1;
      check_eq("rstw_mm", mismatch, 0);
      check_eq("rstw_rdy", rdy, 0);
      check_eq("rstw_err", err_cnt, 0);
      check_eq("rstw_cov", cov, 0);
      check_eq("rstw_done", done, 0);
      tick();
    end
    vld = 1'b0;

    // Randomized runs
    repeat (4) begin
      start_run();
      nv = 0;
      while (!m_done && nv < 40) begin
        ra = 1'($urandom_range(0, 1));
        rb = 1'($urandom_range(0, 1));
        rc = ($urandom_range(0, 3) == 0) ? ~(ra & rb) : (ra & rb);
        do_vector(ra, rb, rc);
        nv++;
      end
      check_eq("rand_done", done, m_done);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, range 1..15: clock edges between vector acceptance and sampling of c.
REQ-002 SHALL have parameter ERR_W, default 8: width of the error counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1: clear results and begin or restart a checking run.
REQ-006 SHALL have port vld, input, 1: the vector on a/b is valid.
REQ-007 SHALL have port rdy, output, 1: checker can accept a vector.
REQ-008 SHALL have ports a and b, input, 1 each: stimulus applied to the AND gate under test.
REQ-009 SHALL have port c, input, 1: AND gate output, consumed by this block.
REQ-010 SHALL have port mismatch, output, 1: one-cycle pulse when sampled c != a&b.
REQ-011 SHALL have port err_cnt, output, ERR_W: saturating mismatch count.
REQ-012 SHALL have port cov, output, 4: cov[{a,b}] set once that input combination has been checked.
REQ-013 SHALL have port done, output, 1: all four combinations checked.
REQ-014 SHALL have port pass, output, 1: done with err_cnt == 0.

Function
REQ-015 SHALL implement the states IDLE, RUN, WAIT, CHECK and DONE.
REQ-016 In IDLE, rdy SHALL be 0 and vld SHALL be ignored; start SHALL move the block to RUN.
REQ-017 In RUN, rdy SHALL be 1; vld&&rdy at an edge SHALL capture a and b into internal registers, load the settle counter and move to WAIT.
REQ-018 rdy SHALL be 0 in WAIT, CHECK, DONE and IDLE (registered, from state).
REQ-019 WAIT SHALL last SETTLE_CYCLES-1 cycles (0 cycles when SETTLE_CYCLES=1) before CHECK; c SHALL be sampled at the edge exactly SETTLE_CYCLES edges after the acceptance edge.
REQ-020 At the CHECK edge, expected SHALL be captured_a & captured_b; on a difference, mismatch SHALL pulse for one cycle and err_cnt SHALL increment.
REQ-021 err_cnt SHALL saturate at 2^ERR_W-1 and never wrap.
REQ-022 At the CHECK edge, cov[{captured_a,captured_b}] SHALL be set regardless of the outcome; repeated vectors SHALL be counted and compared, but coverage is unchanged.
REQ-023 After CHECK, the block SHALL go to DONE if the updated cov == 4'b1111, else to RUN (rdy=1 the following cycle).
REQ-024 In DONE, done SHALL be 1 and pass SHALL equal (err_cnt==0); vld SHALL be ignored.
REQ-025 start in any state other than IDLE SHALL clear cov, err_cnt, done, pass and mismatch, discard any in-flight vector, and enter RUN next cycle.
REQ-026 start and vld in the same cycle SHALL give priority to start; the vector SHALL NOT be accepted.
REQ-027 a and b changing after acceptance SHALL NOT affect the expected value; c SHALL be sampled live at the CHECK edge only.

Reset
REQ-028 rst SHALL take priority over start and all other inputs.
REQ-029 rst SHALL force state IDLE, rdy=0, mismatch=0, err_cnt=0, cov=0, done=0, pass=0, settle counter=0 and captured a/b=0.
REQ-030 rst asserted mid-vector SHALL discard the vector with no counter or coverage update.

Verification
REQ-031 Reset then start, correct gate, vectors 00,01,10,11 (SETTLE_CYCLES=2) -> each c sampled 2 edges after acceptance, mismatch never pulses, cov=1111, done=1, pass=1, err_cnt=0.
REQ-032 c stuck at 1, vectors 00,01,10,11 -> mismatch pulses 3 times, err_cnt=3, done=1, pass=0.
REQ-033 Vectors 11,11,00,01,10 with c correct -> cov stays 1000 after the second vector, done only after the fifth CHECK, err_cnt=0.
REQ-034 ERR_W=2, c stuck at 0, 6 vectors of 11 then 00,01,10 -> err_cnt saturates at 3, done=1, pass=0.
REQ-035 start asserted during WAIT after one error -> err_cnt=0, cov=0, no CHECK for the discarded vector, rdy=1 next cycle.
REQ-036 rst during WAIT with a mismatching c -> no mismatch pulse, all outputs 0, state IDLE; vld ignored until start.
